// File: rtl/writeback_arbiter_pkg.sv
// harmonica_cfg: shared widths and the writeback entry type for the GPR writeback path
//   MACHINE_WIDTH  data width of one register write
//   LOG2_NUM_REGS  register address width
//   WB_FIFO_DEPTH  entries per producer FIFO (power of two, >= 2)
package harmonica_cfg;
    localparam int MACHINE_WIDTH = 32;
    localparam int LOG2_NUM_REGS = 4;
    localparam int WB_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [LOG2_NUM_REGS-1:0] addr;
        logic [MACHINE_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;
endpackage

// File: rtl/writeback_arbiter_if.sv
// wb_if: producer, register-file and hazard-query signals of the writeback arbiter
//   i_alu_*    ALU lane valid/addr/data in, o_alu_ready out
//   i_mem_*    load lane valid/addr/data in, o_mem_ready out
//   o_write_*  registered register-file write port
//   i_query_addr / o_query_hit  pending-write query, o_busy  any work outstanding
//   slave = arbiter side, master = producer/issue side
interface wb_if;
    import harmonica_cfg::*;
    logic                     i_alu_valid;
    logic                     o_alu_ready;
    logic [LOG2_NUM_REGS-1:0] i_alu_addr;
    logic [MACHINE_WIDTH-1:0] i_alu_data;
    logic                     i_mem_valid;
    logic                     o_mem_ready;
    logic [LOG2_NUM_REGS-1:0] i_mem_addr;
    logic [MACHINE_WIDTH-1:0] i_mem_data;
    logic                     o_write_en;
    logic [LOG2_NUM_REGS-1:0] o_write_addr;
    logic [MACHINE_WIDTH-1:0] o_write_data;
    logic [LOG2_NUM_REGS-1:0] i_query_addr;
    logic                     o_query_hit;
    logic                     o_busy;

    modport slave (
        input  i_alu_valid, i_alu_addr, i_alu_data,
        input  i_mem_valid, i_mem_addr, i_mem_data,
        input  i_query_addr,
        output o_alu_ready, o_mem_ready,
        output o_write_en, o_write_addr, o_write_data,
        output o_query_hit, o_busy
    );

    modport master (
        output i_alu_valid, i_alu_addr, i_alu_data,
        output i_mem_valid, i_mem_addr, i_mem_data,
        output i_query_addr,
        input  o_alu_ready, o_mem_ready,
        input  o_write_en, o_write_addr, o_write_data,
        input  o_query_hit, o_busy
    );
endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries with a per-slot valid/addr view
//   clk, rst_n        clock, async active-low reset
//   i_push, i_entry   write one entry (caller guarantees not full)
//   i_pop, o_head     drop the head entry (caller guarantees not empty)
//   o_full, o_empty   occupancy flags
//   o_vld, o_addr     per-slot live flag and destination for hazard compares
module wb_fifo
    import harmonica_cfg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_push,
    input  wb_entry_t                             i_entry,
    input  logic                                  i_pop,
    output wb_entry_t                             o_head,
    output logic                                  o_full,
    output logic                                  o_empty,
    output logic [DEPTH-1:0]                      o_vld,
    output logic [DEPTH-1:0][LOG2_NUM_REGS-1:0]   o_addr
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    wb_entry_t     r_mem [DEPTH];

    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_head  = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_entry;
    end

    // a slot is live when its distance ahead of the read pointer is below the count
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        logic [AW-1:0] w_off;
        assign w_off     = AW'(i) - r_rptr;
        assign o_vld[i]  = {1'b0, w_off} < r_count;
        assign o_addr[i] = r_mem[i].addr;
    end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: buffers ALU and load results and round-robins them onto the GPR write port
//   clk, rst_n   clock, async active-low reset
//   bus (slave)  producer handshakes, registered write port, pending-write query, busy
module writeback_arbiter
    import harmonica_cfg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    wb_if.slave  bus
);
    logic                     r_active;
    wb_src_e                  r_rr;
    logic                     r_write_en;
    logic [LOG2_NUM_REGS-1:0] r_write_addr;
    logic [MACHINE_WIDTH-1:0] r_write_data;

    wb_entry_t w_alu_in, w_mem_in, w_alu_head, w_mem_head;
    logic      w_alu_full, w_alu_empty, w_mem_full, w_mem_empty;
    logic      w_alu_ready, w_mem_ready, w_alu_push, w_mem_push;
    logic      w_alu_pop, w_mem_pop, w_pick_mem, w_hit;
    logic [FIFO_DEPTH-1:0]                    w_alu_vld, w_mem_vld;
    logic [FIFO_DEPTH-1:0][LOG2_NUM_REGS-1:0] w_alu_qaddr, w_mem_qaddr;

    // r_active keeps ready low through reset and for the cycle of release
    assign w_alu_ready = r_active && !w_alu_full;
    assign w_mem_ready = r_active && !w_mem_full;
    assign w_alu_push  = bus.i_alu_valid && w_alu_ready;
    assign w_mem_push  = bus.i_mem_valid && w_mem_ready;
    assign w_alu_in    = '{addr: bus.i_alu_addr, data: bus.i_alu_data};
    assign w_mem_in    = '{addr: bus.i_mem_addr, data: bus.i_mem_data};

    assign w_pick_mem = !w_mem_empty && (w_alu_empty || r_rr == SRC_MEM);
    assign w_mem_pop  = w_pick_mem;
    assign w_alu_pop  = !w_alu_empty && !w_pick_mem;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_alu_push),
        .i_entry (w_alu_in),
        .i_pop   (w_alu_pop),
        .o_head  (w_alu_head),
        .o_full  (w_alu_full),
        .o_empty (w_alu_empty),
        .o_vld   (w_alu_vld),
        .o_addr  (w_alu_qaddr)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_mem_push),
        .i_entry (w_mem_in),
        .i_pop   (w_mem_pop),
        .o_head  (w_mem_head),
        .o_full  (w_mem_full),
        .o_empty (w_mem_empty),
        .o_vld   (w_mem_vld),
        .o_addr  (w_mem_qaddr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active     <= 1'b0;
            r_rr         <= SRC_ALU;
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else begin
            r_active   <= 1'b1;
            // the pointer only moves when both lanes actually competed
            if (!w_alu_empty && !w_mem_empty) r_rr <= w_pick_mem ? SRC_ALU : SRC_MEM;
            r_write_en <= w_alu_pop || w_mem_pop;
            if (w_alu_pop || w_mem_pop) begin
                r_write_addr <= w_pick_mem ? w_mem_head.addr : w_alu_head.addr;
                r_write_data <= w_pick_mem ? w_mem_head.data : w_alu_head.data;
            end
        end
    end

    always_comb begin
        w_hit = r_write_en && r_write_addr == bus.i_query_addr;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            w_hit = w_hit || (w_alu_vld[k] && w_alu_qaddr[k] == bus.i_query_addr)
                          || (w_mem_vld[k] && w_mem_qaddr[k] == bus.i_query_addr);
        end
    end

    assign bus.o_alu_ready  = w_alu_ready;
    assign bus.o_mem_ready  = w_mem_ready;
    assign bus.o_write_en   = r_write_en;
    assign bus.o_write_addr = r_write_addr;
    assign bus.o_write_data = r_write_data;
    assign bus.o_query_hit  = w_hit;
    assign bus.o_busy       = !w_alu_empty || !w_mem_empty || r_write_en;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and randomized checks of writeback_arbiter against a queue model
module tb_writeback_arbiter;
    import harmonica_cfg::*;
    localparam int DEPTH = WB_FIFO_DEPTH;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    wb_if u_if();
    writeback_arbiter #(.FIFO_DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    int n_tests = 0;
    int n_fail = 0;

    wb_entry_t                aq[$];
    wb_entry_t                mq[$];
    wb_entry_t                m_h;
    bit                       m_rr = 0, m_we = 0, m_act = 0;
    bit                       m_pa, m_pm, m_acc_a, m_acc_m, e_hit;
    logic [LOG2_NUM_REGS-1:0] m_wa = '0;
    logic [MACHINE_WIDTH-1:0] m_wd = '0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // reference: two queues, a fairness bit that flips whenever both lanes compete
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aq.delete();
            mq.delete();
            m_rr  = 0;
            m_we  = 0;
            m_wa  = '0;
            m_wd  = '0;
            m_act = 0;
        end else begin
            m_acc_a = u_if.i_alu_valid && m_act && aq.size() < DEPTH;
            m_acc_m = u_if.i_mem_valid && m_act && mq.size() < DEPTH;
            m_pm = mq.size() > 0 && (aq.size() == 0 || m_rr);
            m_pa = aq.size() > 0 && !m_pm;
            if (aq.size() > 0 && mq.size() > 0) m_rr = !m_rr;
            m_we = m_pa || m_pm;
            if (m_pa) m_h = aq.pop_front();
            if (m_pm) m_h = mq.pop_front();
            if (m_we) begin
                m_wa = m_h.addr;
                m_wd = m_h.data;
            end
            if (m_acc_a) aq.push_back('{addr: u_if.i_alu_addr, data: u_if.i_alu_data});
            if (m_acc_m) mq.push_back('{addr: u_if.i_mem_addr, data: u_if.i_mem_data});
            m_act = 1;
        end
    end

    always @(negedge clk) begin
        e_hit = m_we && m_wa == u_if.i_query_addr;
        foreach (aq[i]) if (aq[i].addr == u_if.i_query_addr) e_hit = 1;
        foreach (mq[i]) if (mq[i].addr == u_if.i_query_addr) e_hit = 1;
        chk("write_en", u_if.o_write_en, m_we);
        if (m_we) begin
            chk("write_addr", u_if.o_write_addr, m_wa);
            chk("write_data", u_if.o_write_data, m_wd);
        end
        chk("alu_ready", u_if.o_alu_ready, m_act && aq.size() < DEPTH);
        chk("mem_ready", u_if.o_mem_ready, m_act && mq.size() < DEPTH);
        chk("busy", u_if.o_busy, aq.size() > 0 || mq.size() > 0 || m_we);
        chk("query_hit", u_if.o_query_hit, e_hit);
    end

    task automatic idle();
        u_if.i_alu_valid = 1'b0;
        u_if.i_mem_valid = 1'b0;
    endtask

    initial begin
        int na, nm, first, last, mw;
        bit seen0;
        logic [31:0] wlog[$];
        idle();
        u_if.i_alu_addr = '0;
        u_if.i_alu_data = '0;
        u_if.i_mem_addr = '0;
        u_if.i_mem_data = '0;
        u_if.i_query_addr = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_we", u_if.o_write_en, 0);
        chk("rst_wa", u_if.o_write_addr, 0);
        chk("rst_wd", u_if.o_write_data, 0);
        chk("rst_alu_ready", u_if.o_alu_ready, 0);
        chk("rst_mem_ready", u_if.o_mem_ready, 0);
        chk("rst_busy", u_if.o_busy, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_alu_ready", u_if.o_alu_ready, 1);
        chk("rel_mem_ready", u_if.o_mem_ready, 1);

        // single ALU write latency
        #1;
        u_if.i_alu_valid = 1'b1;
        u_if.i_alu_addr = 4'd5;
        u_if.i_alu_data = 32'hDEAD0005;
        @(negedge clk);
        chk("t1_we_early", u_if.o_write_en, 0);
        chk("t1_busy", u_if.o_busy, 1);
        #1 idle();
        @(negedge clk);
        chk("t1_we", u_if.o_write_en, 1);
        chk("t1_wa", u_if.o_write_addr, 5);
        chk("t1_wd", u_if.o_write_data, 32'hDEAD0005);
        @(negedge clk);
        chk("t1_we_after", u_if.o_write_en, 0);
        chk("t1_busy_after", u_if.o_busy, 0);

        // query hit window
        #1;
        u_if.i_alu_valid = 1'b1;
        u_if.i_alu_addr = 4'd3;
        u_if.i_alu_data = $urandom;
        u_if.i_query_addr = 4'd3;
        @(negedge clk);
        chk("t4_hit_queued", u_if.o_query_hit, 1);
        #1 idle();
        @(negedge clk);
        chk("t4_hit_writing", u_if.o_query_hit, 1);
        chk("t4_we", u_if.o_write_en, 1);
        chk("t4_wa", u_if.o_write_addr, 3);
        @(negedge clk);
        chk("t4_hit_gone", u_if.o_query_hit, 0);

        // both lanes streaming: strict alternation starting with ALU, no bubbles
        na = 0;
        nm = 0;
        first = -1;
        last = -1;
        for (int c = 0; c < 80 && wlog.size() < 16; c++) begin
            @(negedge clk);
            if (u_if.o_write_en) begin
                wlog.push_back(u_if.o_write_data);
                if (first < 0) first = c;
                last = c;
            end
            #1;
            u_if.i_alu_valid = na < 8;
            u_if.i_alu_addr = LOG2_NUM_REGS'(na + 1);
            u_if.i_alu_data = 32'hA0000000 + na;
            u_if.i_mem_valid = nm < 8;
            u_if.i_mem_addr = LOG2_NUM_REGS'(nm + 9);
            u_if.i_mem_data = 32'hB0000000 + nm;
            if (u_if.i_alu_valid && u_if.o_alu_ready) na++;
            if (u_if.i_mem_valid && u_if.o_mem_ready) nm++;
        end
        idle();
        chk("t2_count", wlog.size(), 16);
        for (int k = 0; k < wlog.size() && k < 16; k++)
            chk($sformatf("t2_order%0d", k), wlog[k],
                (k % 2 == 0) ? 32'hA0000000 + k / 2 : 32'hB0000000 + k / 2);
        chk("t2_no_bubble", last - first, 15);

        // MEM held while ALU keeps the write port loaded
        nm = 0;
        mw = 0;
        seen0 = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (u_if.o_write_en && u_if.o_write_data[31:28] == 4'hC) mw++;
            if (u_if.i_mem_valid && !u_if.o_mem_ready) seen0 = 1;
            #1;
            u_if.i_alu_valid = c < 30;
            u_if.i_alu_addr = LOG2_NUM_REGS'($urandom);
            u_if.i_alu_data = 32'hD0000000 + c;
            u_if.i_mem_valid = c < 30;
            u_if.i_mem_addr = LOG2_NUM_REGS'($urandom);
            u_if.i_mem_data = 32'hC0000000 + nm;
            if (u_if.i_mem_valid && u_if.o_mem_ready) nm++;
        end
        chk("t3_mem_backpressure", seen0, 1);
        chk("t3_mem_writes", mw, nm);
        chk("t3_idle", u_if.o_busy, 0);

        // asynchronous reset with both FIFOs loaded
        u_if.i_alu_valid = 1'b1;
        u_if.i_mem_valid = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_busy_before", u_if.o_busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_we", u_if.o_write_en, 0);
        chk("t5_alu_ready", u_if.o_alu_ready, 0);
        chk("t5_mem_ready", u_if.o_mem_ready, 0);
        chk("t5_busy", u_if.o_busy, 0);
        idle();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rel_alu_ready", u_if.o_alu_ready, 1);
        chk("t5_rel_mem_ready", u_if.o_mem_ready, 1);
        chk("t5_rel_busy", u_if.o_busy, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_write", u_if.o_write_en, 0);
        end

        // same destination from both lanes in one cycle
        #1;
        u_if.i_alu_valid = 1'b1;
        u_if.i_alu_addr = 4'd7;
        u_if.i_alu_data = 32'h11;
        u_if.i_mem_valid = 1'b1;
        u_if.i_mem_addr = 4'd7;
        u_if.i_mem_data = 32'h22;
        @(negedge clk);
        chk("t6_we_early", u_if.o_write_en, 0);
        #1 idle();
        @(negedge clk);
        chk("t6_first_we", u_if.o_write_en, 1);
        chk("t6_first_wa", u_if.o_write_addr, 7);
        chk("t6_first_wd", u_if.o_write_data, 32'h11);
        @(negedge clk);
        chk("t6_second_we", u_if.o_write_en, 1);
        chk("t6_second_wa", u_if.o_write_addr, 7);
        chk("t6_second_wd", u_if.o_write_data, 32'h22);
        @(negedge clk);
        chk("t6_done", u_if.o_write_en, 0);

        // randomized traffic with sweeping densities
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            u_if.i_alu_valid = $urandom_range(0, 3) <= (c / 500) % 4;
            u_if.i_mem_valid = $urandom_range(0, 3) <= ((c / 500) + 1) % 4;
            u_if.i_alu_addr = LOG2_NUM_REGS'($urandom);
            u_if.i_alu_data = $urandom;
            u_if.i_mem_addr = LOG2_NUM_REGS'($urandom);
            u_if.i_mem_data = $urandom;
            u_if.i_query_addr = LOG2_NUM_REGS'($urandom);
        end
        idle();
        repeat (12) @(negedge clk);
        chk("final_idle", u_if.o_busy, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
